// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//   ID->EX stage of the rv32 pipeline. It decodes one RV32I instruction per
//   cycle into the ALU select code, the operand-source selects, the immediate
//   and the control enables that EX consumes. The result is then registered
//   into the ID/EX pipeline register.
//
//   Handshake: the stage accepts an instruction on a cycle when id_ready is 1.
//   A flush always accepts, because the incoming word is dropped for a
//   bubble. A stall without a flush holds the register, so id_ready is 0 on
//   that cycle.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid/_instr/_pc incoming instruction word, its pc and a valid flag
//   ex_stall, ex_flush  hold the EX register / load a bubble (flush wins)
//   id_ready            combinational: !ex_stall | ex_flush
//   ex_*                registered decode results (see port list)
// ---------------------------------------------------------------------------
module alu_decode_stage #(
  parameter int unsigned XLEN         = 32,
  parameter bit          NOP_ON_FENCE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic            ex_stall,
  input  logic            ex_flush,
  output logic            id_ready,
  output logic            ex_valid,
  output logic            ex_illegal,
  output logic [3:0]      ex_alu_sel,
  output logic [1:0]      ex_src1_sel,
  output logic            ex_src2_sel,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [2:0]      ex_mem_size,
  output logic            ex_branch,
  output logic [2:0]      ex_branch_type,
  output logic            ex_jump
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_UPPER = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_SLT   = 4'b1011;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic [3:0]      alu_sel;
    logic [1:0]      src1_sel;
    logic            src2_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_size;
    logic            branch;
    logic [2:0]      branch_type;
    logic            jump;
  } ex_reg_t;

  ex_reg_t dec;
  ex_reg_t ex_d;
  ex_reg_t ex_q;
  logic    legal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];
  assign funct7 = id_instr[31:25];

  assign imm_i = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
                  id_instr[30:25], id_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){id_instr[31]}}, id_instr[31], id_instr[19:12],
                  id_instr[20], id_instr[30:21], 1'b0};
  // U immediate is left unshifted: the ALU's UPPER op applies the <<12.
  assign imm_u = {{(XLEN-20){1'b0}}, id_instr[31:12]};

  // Shared funct3 -> ALU code map of the register and immediate ALU ops.
  // funct3 101 (right shifts) has no ALU op and is rejected by the callers.
  function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3,
                                               input logic       sub);
    case (f3)
      3'b000:  alu_of_funct3 = sub ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of_funct3 = ALU_SLL;
      3'b010:  alu_of_funct3 = ALU_SLT;
      3'b011:  alu_of_funct3 = ALU_SLTU;
      3'b100:  alu_of_funct3 = ALU_XOR;
      3'b110:  alu_of_funct3 = ALU_OR;
      default: alu_of_funct3 = ALU_AND;
    endcase
  endfunction

  // Combinational decode of id_instr.
  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    dec.rs1 = id_instr[19:15];
    dec.rs2 = id_instr[24:20];
    dec.rd  = id_instr[11:7];
    case (opcode)
      OP_R: begin
        legal = ((funct7 == 7'b0000000) && (funct3 != 3'b101)) ||
                ((funct7 == 7'b0100000) && (funct3 == 3'b000));
        dec.alu_sel   = alu_of_funct3(funct3, funct7[5]);
        dec.reg_write = 1'b1;
      end
      OP_IMM: begin
        legal = (funct3 != 3'b101) && ((funct3 != 3'b001) || (funct7 == 7'b0));
        dec.alu_sel   = alu_of_funct3(funct3, 1'b0);
        dec.src2_sel  = 1'b1;
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        legal         = 1'b1;
        dec.alu_sel   = ALU_UPPER;
        dec.src1_sel  = (opcode == OP_LUI) ? 2'b10 : 2'b01;
        dec.src2_sel  = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        dec.alu_sel   = ALU_ADD;
        dec.src2_sel  = 1'b1;
        dec.imm       = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_size  = funct3;
      end
      OP_STORE: begin
        legal = (funct3 <= 3'b010);
        dec.alu_sel   = ALU_ADD;
        dec.src2_sel  = 1'b1;
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
        dec.mem_size  = funct3;
      end
      OP_BRANCH: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        // EQ/NE use the SUB zero flag; signed and unsigned compares use SLT/SLTU.
        dec.alu_sel     = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        dec.imm         = imm_b;
        dec.branch      = 1'b1;
        dec.branch_type = funct3;
      end
      OP_JAL: begin
        legal         = 1'b1;
        dec.alu_sel   = ALU_ADD;
        dec.src1_sel  = 2'b01;
        dec.src2_sel  = 1'b1;
        dec.imm       = imm_j;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        legal         = (funct3 == 3'b000);
        dec.alu_sel   = ALU_ADD;
        dec.src2_sel  = 1'b1;
        dec.imm       = imm_i;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_FENCE: begin
        legal = NOP_ON_FENCE;
      end
      default: legal = 1'b0;  // includes SYSTEM and instr[1:0] != 11
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    dec.valid = 1'b1;
    // Unsupported work still travels down the pipe so EX can trap on it,
    // but it carries only its pc and the illegal flag.
    if (!legal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end
    dec.pc = id_pc;
  end

  // Update priority: flush, then stall (hold), then load or bubble.
  always_comb begin
    ex_d = ex_q;
    if (ex_flush)      ex_d = '0;
    else if (ex_stall) ex_d = ex_q;
    else if (id_valid) ex_d = dec;
    else               ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign id_ready       = !ex_stall || ex_flush;
  assign ex_valid       = ex_q.valid;
  assign ex_illegal     = ex_q.illegal;
  assign ex_alu_sel     = ex_q.alu_sel;
  assign ex_src1_sel    = ex_q.src1_sel;
  assign ex_src2_sel    = ex_q.src2_sel;
  assign ex_imm         = ex_q.imm;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_rd          = ex_q.rd;
  assign ex_pc          = ex_q.pc;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_mem_size    = ex_q.mem_size;
  assign ex_branch      = ex_q.branch;
  assign ex_branch_type = ex_q.branch_type;
  assign ex_jump        = ex_q.jump;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

  // Expected EX register contents. 'loose' marks entries (illegal, FENCE)
  // where only valid/illegal/alu_sel/enables/pc carry meaning.
  typedef struct packed {
    logic        loose;
    logic        valid;
    logic        illegal;
    logic [3:0]  alu_sel;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic        branch;
    logic [2:0]  branch_type;
    logic        jump;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic        ex_stall = 1'b0;
  logic        ex_flush = 1'b0;
  logic        id_ready, ex_valid, ex_illegal, ex_src2_sel;
  logic [3:0]  ex_alu_sel;
  logic [1:0]  ex_src1_sel;
  logic [31:0] ex_imm, ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic [2:0]  ex_mem_size, ex_branch_type;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32), .NOP_ON_FENCE(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_illegal(ex_illegal), .ex_alu_sel(ex_alu_sel),
    .ex_src1_sel(ex_src1_sel), .ex_src2_sel(ex_src2_sel), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_branch(ex_branch), .ex_branch_type(ex_branch_type), .ex_jump(ex_jump)
  );

  // ---------------- reference model ----------------
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t held;   // what the EX register is expected to hold right now

  string r_names[8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
  string b_names[8] = '{"SUB", "SUB", "", "", "SLT", "SLT", "SLTU", "SLTU"};

  // ALU code by operation name; names without an ALU op give ok=0.
  function automatic void code_of(input string m, output logic [3:0] c, output bit ok);
    ok = 1'b1;
    case (m)
      "AND":   c = 4'b0000;
      "OR":    c = 4'b0001;
      "ADD":   c = 4'b0010;
      "SUB":   c = 4'b0011;
      "SLTU":  c = 4'b0100;
      "UPPER": c = 4'b0111;
      "SLL":   c = 4'b1000;
      "XOR":   c = 4'b1001;
      "SLT":   c = 4'b1011;
      default: begin c = 4'b0000; ok = 1'b0; end
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    string      m;
    bit         ok;
    logic [3:0] c;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    int         sgn;
    e   = '0;
    m   = "";
    f3  = ins[14:12];
    f7  = ins[31:25];
    sgn = ins[31] ? 1 : 0;
    imm_i = 32'($signed(ins) >>> 20);
    imm_s = 32'(-2048 * sgn + int'(ins[30:25]) * 32 + int'(ins[11:7]));
    imm_b = 32'(-4096 * sgn + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
    imm_j = 32'(-1048576 * sgn + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        m = r_names[f3];
        if (f7 == 7'h20) m = (f3 == 3'd0) ? "SUB" : "";
        else if (f7 != 7'h00) m = "";
        e.reg_write = 1'b1;
      end
      7'h13: begin
        m = r_names[f3];
        if (f3 == 3'd1 && f7 != 7'h00) m = "";
        e.src2_sel = 1'b1; e.imm = imm_i; e.reg_write = 1'b1;
      end
      7'h37: begin m = "UPPER"; e.src1_sel = 2'b10; e.src2_sel = 1'b1; e.imm = ins >> 12; e.reg_write = 1'b1; end
      7'h17: begin m = "UPPER"; e.src1_sel = 2'b01; e.src2_sel = 1'b1; e.imm = ins >> 12; e.reg_write = 1'b1; end
      7'h03: begin
        m = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? "ADD" : "";
        e.src2_sel = 1'b1; e.imm = imm_i; e.mem_read = 1'b1; e.reg_write = 1'b1; e.mem_size = f3;
      end
      7'h23: begin
        m = (f3 <= 3'd2) ? "ADD" : "";
        e.src2_sel = 1'b1; e.imm = imm_s; e.mem_write = 1'b1; e.mem_size = f3;
      end
      7'h63: begin m = b_names[f3]; e.imm = imm_b; e.branch = 1'b1; e.branch_type = f3; end
      7'h6f: begin m = "ADD"; e.src1_sel = 2'b01; e.src2_sel = 1'b1; e.imm = imm_j; e.jump = 1'b1; e.reg_write = 1'b1; end
      7'h67: begin
        m = (f3 == 3'd0) ? "ADD" : "";
        e.src2_sel = 1'b1; e.imm = imm_i; e.jump = 1'b1; e.reg_write = 1'b1;
      end
      7'h0f: m = "FENCE";
      default: m = "";
    endcase
    if (m == "FENCE") begin
      e = '0; e.valid = 1'b1; e.loose = 1'b1; e.pc = pc;
      return e;
    end
    code_of(m, c, ok);
    if (!ok) begin
      e = '0; e.valid = 1'b1; e.illegal = 1'b1; e.loose = 1'b1; e.pc = pc;
      return e;
    end
    e.alu_sel = c;
    if (e.rd == 5'd0) e.reg_write = 1'b0;
    e.valid = 1'b1;
    e.pc    = pc;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit v, input logic [31:0] ins,
                      input logic [31:0] pc, input bit st, input bit fl);
    @(negedge clk);
    rst = r; id_valid = v; id_instr = ins; id_pc = pc; ex_stall = st; ex_flush = fl;
    if (r || fl)  held = '0;
    else if (st)  held = held;
    else if (v)   held = model(ins, pc);
    else          held = '0;
    exp_q.push_back(held);
    #1;
    checks++;
    if (id_ready !== (!st || fl)) begin
      errors++;
      $display("FAIL id_ready t=%0t got %b want %b", $time, id_ready, !st || fl);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{e.loose, ex_valid, ex_illegal, ex_alu_sel, ex_src1_sel, ex_src2_sel, ex_imm,
            ex_rs1, ex_rs2, ex_rd, ex_pc, ex_reg_write, ex_mem_read, ex_mem_write,
            ex_mem_size, ex_branch, ex_branch_type, ex_jump};
      if (e.loose) begin
        a.src1_sel = '0; a.src2_sel = '0; a.imm = '0; a.rs1 = '0; a.rs2 = '0; a.rd = '0;
        e.src1_sel = '0; e.src2_sel = '0; e.imm = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
      end
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ex_reg t=%0t got v=%b il=%b alu=%h s1=%0d s2=%0d imm=%h rs=%0d,%0d rd=%0d pc=%h we=%b mr=%b mw=%b ms=%0d br=%b bt=%0d j=%b want v=%b il=%b alu=%h s1=%0d s2=%0d imm=%h rs=%0d,%0d rd=%0d pc=%h we=%b mr=%b mw=%b ms=%0d br=%b bt=%0d j=%b",
                 $time, a.valid, a.illegal, a.alu_sel, a.src1_sel, a.src2_sel, a.imm, a.rs1, a.rs2, a.rd,
                 a.pc, a.reg_write, a.mem_read, a.mem_write, a.mem_size, a.branch, a.branch_type, a.jump,
                 e.valid, e.illegal, e.alu_sel, e.src1_sel, e.src2_sel, e.imm, e.rs1, e.rs2, e.rd,
                 e.pc, e.reg_write, e.mem_read, e.mem_write, e.mem_size, e.branch, e.branch_type, e.jump);
      end
    end
  end

  // Random instruction of a chosen class, with random fields elsewhere.
  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [11];
    logic [6:0]  f7s [4];
    int          k;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h0f, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    w = $urandom();
    k = $urandom_range(0, 12);
    if (k <= 10) w[6:0] = ops[k];
    if ((k == 0 || k == 1) && $urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    held = '0;
    // reset for two cycles, then idle
    step(1, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    // directed decode cases
    step(0, 1, 32'h002081B3, 32'h0000_0040, 0, 0);  // ADD x3,x1,x2
    step(0, 1, 32'h402081B3, 32'h0000_0044, 0, 0);  // SUB
    step(0, 1, 32'h123452B7, 32'h0000_0048, 0, 0);  // LUI x5,0x12345
    step(0, 1, 32'h00208463, 32'h0000_0100, 0, 0);  // BEQ x1,x2,+8
    step(0, 1, 32'h4020D1B3, 32'h0000_0104, 0, 0);  // SRA (illegal)
    step(0, 1, 32'h00000013, 32'h0000_0108, 0, 0);  // NOP, rd=0
    step(0, 1, 32'hFFF0_0F0F, 32'h0000_010C, 0, 0);  // FENCE
    step(0, 1, 32'h0220_81B3, 32'h0000_0110, 0, 0);  // MUL (illegal)
    step(0, 1, 32'h0000_0073, 32'h0000_0114, 0, 0);  // ECALL (illegal)
    // stall holds ADD for 3 cycles while new words arrive, then stall+flush
    step(0, 1, 32'h002081B3, 32'h0000_0200, 0, 0);
    step(0, 1, 32'h123452B7, 32'h0000_0204, 1, 0);
    step(0, 1, 32'h00208463, 32'h0000_0208, 1, 0);
    step(0, 1, 32'h4020D1B3, 32'h0000_020C, 1, 0);
    step(0, 1, 32'h402081B3, 32'h0000_0210, 1, 1);
    // reset while stalled clears the same edge
    step(0, 1, 32'h002081B3, 32'h0000_0300, 0, 0);
    step(1, 1, 32'h402081B3, 32'h0000_0304, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, rand_instr(),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8);
    end
    step(0, 0, 32'h0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
